display_scan_mux: RTL and testbench

- Time-multiplexes four BCD digits onto a 4-digit common-anode display; sits directly upstream of seven_segment_display.
- Each cycle it presents one digit on num, which the decoder turns into segments, and drives the matching active-low anode.
- Adds anti-ghosting dead time, per-digit blink for set/adjust mode, leading-zero suppression, and per-frame snapshotting so the stopwatch count never tears mid-scan.

---
 rtl/display_pkg.sv | 15 +
 rtl/display_scan_mux_if.sv | 22 ++
 rtl/tick_gen.sv | 31 +++
 rtl/display_scan_mux.sv | 108 ++++++++++
 tb/tb_display_scan_mux.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit display scanner.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [3:0]  ANODES_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [3:0] anode_for(digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Digit/control inputs and anode/segment-code outputs of the display scanner.
interface display_scan_mux_if;

    logic [15:0] digits;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic        lz_en;
    logic [3:0]  an;
    logic [3:0]  num;
    logic        frame_start;

    modport master (
        output digits, blink_en, blink_mask, lz_en,
        input  an, num, frame_start
    );

    modport slave (
        input  digits, blink_en, blink_mask, lz_en,
        output an, num, frame_start
    );

endinterface

// File: rtl/tick_gen.sv
// Modulo-DIV counter with synchronous clear; wrap is high in the cycle the count rolls over.
module tick_gen #(
    parameter  int unsigned DIV = 2,
    localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_d;

    always_comb begin
        wrap  = !clr && (cnt == W'(DIV - 1));
        cnt_d = cnt + W'(1);
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Scans four snapshotted BCD digits onto a common-anode display with guard time,
// per-digit blink and leading-zero blanking of the leftmost digit.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 8,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input logic               clk,
    input logic               rst_n,
    display_scan_mux_if.slave bus
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] ref_cnt;
    logic          ref_wrap;
    logic [BW-1:0] blink_cnt;
    logic          blink_wrap;
    logic          blink_clr;

    digit_idx_t    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic          blink_phase_q, blink_phase_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    num_q, num_d;
    logic          frame_start_q, frame_start_d;

    logic          snap_take;
    logic          blank;
    logic [3:0]    cur_digit;

    assign blink_clr = !bus.blink_en;

    tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .cnt   (ref_cnt),
        .wrap  (ref_wrap)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (blink_clr),
        .cnt   (blink_cnt),
        .wrap  (blink_wrap)
    );

    always_comb begin
        snap_take     = (ref_cnt == '0) && (idx_q == 2'd0);
        idx_d         = ref_wrap ? idx_q + 2'd1 : idx_q;
        snap_d        = snap_take ? bus.digits : snap_q;
        frame_start_d = snap_take;

        blink_phase_d = blink_phase_q;
        if (!bus.blink_en) begin
            blink_phase_d = 1'b1;
        end else if (blink_wrap) begin
            blink_phase_d = !blink_phase_q;
        end

        cur_digit = snap_q[{idx_q, 2'b00} +: 4];
        blank     = (bus.blink_en && bus.blink_mask[idx_q] && !blink_phase_q) ||
                    (bus.lz_en && (idx_q == 2'd3) && (snap_q[15:12] == 4'h0));

        // Codes 10..15 pass through with the anode driven; the decoder blanks them.
        an_d  = ANODES_OFF;
        num_d = BLANK_CODE;
        if ((32'(ref_cnt) >= GUARD) && !blank) begin
            an_d  = anode_for(idx_q);
            num_d = cur_digit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= 2'd0;
            snap_q        <= 16'h0000;
            blink_phase_q <= 1'b1;
            an_q          <= ANODES_OFF;
            num_q         <= BLANK_CODE;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            num_q         <= num_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.num         = num_q;
    assign bus.frame_start = frame_start_q;

    a_ref_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(ref_cnt) < REFRESH_DIV);
    a_blink_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(blink_cnt) < BLINK_DIV);
    a_one_anode: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(~an_q) <= 1);

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench: per-frame expectations are queued ahead of time and a negedge
// monitor pops one entry per cycle; a second process checks scan invariants.
module tb_display_scan_mux;
    import display_pkg::*;

    localparam int unsigned RDIV = 8;
    localparam int unsigned GRD  = 2;
    localparam int unsigned BDIV = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_mux_if bus ();

    display_scan_mux #(
        .REFRESH_DIV (RDIV),
        .GUARD       (GRD),
        .BLINK_DIV   (BDIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [3:0] num;
        logic       fs;
        int         tag;
        int         j;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   armed    = 1'b0;

    function automatic logic [3:0] an_of(int idx);
        case (idx)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Expected outputs for frame cycles [from, upto) given snapshot d and per-slot blanking.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] blank, input int tag,
                              input int from, input int upto);
        for (int j = from; j < upto; j++) begin
            exp_t e;
            int   idx;
            idx   = j / 8;
            e.tag = tag;
            e.j   = j;
            e.fs  = (j == 0);
            if ((j % 8) < GRD || blank[idx]) begin
                e.an  = 4'b1111;
                e.num = 4'hF;
            end else begin
                e.an  = an_of(idx);
                e.num = d[idx*4 +: 4];
            end
            q.push_back(e);
        end
    endtask

    task automatic push_blank(input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.an  = 4'b1111;
            e.num = 4'hF;
            e.fs  = 1'b0;
            e.tag = tag;
            e.j   = -1;
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_last();
        repeat (31) tick();
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 64; i++) begin
            tick();
            if (bus.frame_start === 1'b1) begin
                n_checks++;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL frame_start_wait: got no frame_start within 64 cycles, required one");
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!armed && rst_n && bus.frame_start && q.size() > 0) armed = 1'b1;
        if (armed) begin
            if (q.size() == 0) begin
                armed = 1'b0;
            end else begin
                e = q.pop_front();
                n_checks++;
                if (bus.an !== e.an || bus.num !== e.num || bus.frame_start !== e.fs) begin
                    n_fail++;
                    $display("FAIL scan_t%0d_c%0d: got an=%b num=%h fs=%b, required an=%b num=%h fs=%b",
                             e.tag, e.j, bus.an, bus.num, bus.frame_start, e.an, e.num, e.fs);
                end
            end
        end
    end

    // Invariant checker: single anode, guard window, frame period.
    int cyc  = 0;
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
            cyc  = 0;
        end else begin
            n_checks++;
            if ($countones(~bus.an) > 1) begin
                n_fail++;
                $display("FAIL onehot_an: got an=%b, required at most one low bit", bus.an);
            end
            if (bus.frame_start) begin
                if (seen) begin
                    n_checks++;
                    if (cyc != 32) begin
                        n_fail++;
                        $display("FAIL fs_period: got %0d cycles, required 32", cyc);
                    end
                end
                seen = 1'b1;
                cyc  = 0;
            end
            if (seen) begin
                if ((cyc % 8) < GRD) begin
                    n_checks++;
                    if (bus.an !== 4'b1111) begin
                        n_fail++;
                        $display("FAIL guard_an: got an=%b at slot cycle %0d, required 1111",
                                 bus.an, cyc % 8);
                    end
                end
                cyc++;
                if (cyc == 33) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fs_missing: got no frame_start after 32 cycles, required one");
                end
            end
        end
    end

    initial begin
        bus.digits     = 16'h1234;
        bus.blink_en   = 1'b0;
        bus.blink_mask = 4'b0000;
        bus.lz_en      = 1'b0;
        rst_n          = 1'b0;

        // Basic scan, two identical frames.
        push_frame(16'h1234, 4'b0000, 1, 0, 32);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_fs();
        to_last();
        push_frame(16'h1234, 4'b0000, 1, 0, 32);

        // Digits change mid-frame (idx 2) must not tear.
        tick();
        repeat (18) tick();
        bus.digits = 16'h5678;
        repeat (13) tick();
        push_frame(16'h5678, 4'b0000, 2, 0, 32);

        // Blink digits 0 and 1: visible, blank, visible, blank with early disable.
        tick();
        to_last();
        bus.blink_en   = 1'b1;
        bus.blink_mask = 4'b0011;
        push_frame(16'h5678, 4'b0000, 3, 0, 32);
        tick();
        to_last();
        push_frame(16'h5678, 4'b0011, 3, 0, 32);
        tick();
        to_last();
        push_frame(16'h5678, 4'b0000, 3, 0, 32);
        tick();
        to_last();
        push_frame(16'h5678, 4'b0011, 3, 0, 5);
        push_frame(16'h5678, 4'b0000, 3, 5, 32);
        tick();
        repeat (4) tick();
        bus.blink_en = 1'b0;
        repeat (27) tick();

        // Leading-zero suppression.
        bus.lz_en  = 1'b1;
        bus.digits = 16'h0459;
        push_frame(16'h0459, 4'b1000, 4, 0, 32);
        tick();
        to_last();
        bus.lz_en = 1'b0;
        push_frame(16'h0459, 4'b0000, 4, 0, 32);
        tick();
        to_last();
        bus.lz_en  = 1'b1;
        bus.digits = 16'hA000;
        push_frame(16'hA000, 4'b0000, 4, 0, 32);

        // Reset mid-slot (idx 2, ref_cnt 5), then fresh snapshot.
        tick();
        to_last();
        bus.lz_en  = 1'b0;
        bus.digits = 16'h1234;
        push_frame(16'h1234, 4'b0000, 5, 0, 20);
        push_blank(5, 4);
        tick();
        repeat (20) tick();
        rst_n      = 1'b0;
        bus.digits = 16'h9876;
        repeat (3) tick();
        rst_n = 1'b1;
        push_frame(16'h9876, 4'b0000, 5, 0, 32);
        wait_fs();
        to_last();

        // Random inputs; only the invariant checker is active here.
        repeat (10000) begin
            bus.digits     = 16'($urandom);
            bus.blink_en   = 1'($urandom);
            bus.blink_mask = 4'($urandom);
            bus.lz_en      = 1'($urandom);
            tick();
        end
        repeat (2) tick();

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending entries, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
